// File: rtl/bcd_xs3_seq_pkg.sv
// Shared definitions for the sequential BCD-to-excess-3 converter: FSM states,
// digit-map constants and the per-digit result record.
package bcd_xs3_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [3:0] XS3_OFFSET  = 4'd3;
    localparam logic [3:0] BCD_MAX     = 4'd9;
    localparam logic [3:0] XS3_INVALID = 4'h0;

    typedef struct packed {
        logic [3:0] xs3;
        logic       invalid;
    } digit_res_t;

    function automatic digit_res_t xs3_map(input logic [3:0] bcd);
        digit_res_t r;
        if (bcd > BCD_MAX) begin
            r.xs3     = XS3_INVALID;
            r.invalid = 1'b1;
        end else begin
            r.xs3     = bcd + XS3_OFFSET;
            r.invalid = 1'b0;
        end
        return r;
    endfunction

endpackage

// File: rtl/bcd_xs3_seq_conv.sv
// Single-digit combinational BCD-to-excess-3 converter; shared by all digits of
// a word through the top-level nibble mux.
module xs3_digit_conv
    import bcd_xs3_seq_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [3:0] xs3,
    output logic       invalid
);

    digit_res_t res;

    always_comb begin
        res     = xs3_map(bcd);
        xs3     = res.xs3;
        invalid = res.invalid;
    end

endmodule

// File: rtl/bcd_xs3_seq.sv
// Multi-digit BCD-to-excess-3 converter: captures a word, walks its nibbles
// LSD-first through one shared digit converter and holds the result until taken.
module bcd_xs3_seq
    import bcd_xs3_seq_pkg::*;
#(
    parameter int DIGITS = 4,
    parameter int DW     = 4 * DIGITS,
    parameter int CNTW   = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [DW-1:0]   in_bcd,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [DW-1:0]   out_xs3,
    output logic            out_err,
    output logic            busy,
    output logic [CNTW-1:0] conv_cnt
);

    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(DIGITS - 1);

    state_t                  state, state_nxt;
    logic [IW-1:0]           idx;
    logic [DIGITS-1:0][3:0]  cap_q;
    logic [DIGITS-1:0][3:0]  res_q;
    logic                    err_q;
    logic                    accept, conv_last, out_hs;
    logic [3:0]              nib, nib_xs3;
    logic                    nib_bad;

    // Nibble select feeding the single shared converter.
    always_comb begin
        nib = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (idx == IW'(i)) nib = cap_q[i];
        end
    end

    xs3_digit_conv u_conv (
        .bcd     (nib),
        .xs3     (nib_xs3),
        .invalid (nib_bad)
    );

    assign in_ready = (state == IDLE);
    assign busy     = (state != IDLE);
    assign out_xs3  = res_q;
    assign out_err  = err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        conv_last = 1'b0;
        out_hs    = 1'b0;
        case (state)
            IDLE: begin
                if (in_valid) begin
                    accept    = 1'b1;
                    state_nxt = CONV;
                end
            end
            CONV: begin
                if (idx == LAST_IDX) begin
                    conv_last = 1'b1;
                    state_nxt = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    out_hs    = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cap_q <= '0;
            res_q <= '0;
            err_q <= 1'b0;
            idx   <= '0;
        end else if (accept) begin
            cap_q <= in_bcd;
            res_q <= '0;
            err_q <= 1'b0;
            idx   <= '0;
        end else if (state == CONV) begin
            for (int i = 0; i < DIGITS; i++) begin
                if (idx == IW'(i)) res_q[i] <= nib_xs3;
            end
            err_q <= err_q | nib_bad;
            idx   <= conv_last ? '0 : idx + IW'(1);
        end
    end

    // out_valid tracks the registered state so it is high exactly in DONE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            conv_cnt  <= '0;
        end else begin
            out_valid <= (state_nxt == DONE);
            if (out_hs) conv_cnt <= conv_cnt + CNTW'(1);
        end
    end

endmodule
